// File: rtl/debounce_pulser.sv
// Button debouncer: two-flop synchronizer, qualification FSM, press/release
// strobes and a wrapping press counter. All outputs come straight from flops.
module debounce_pulser #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic       btn_in,
  output logic       level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] press_count
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               s1;
  logic               s2;

  // Metastability guard for the asynchronous button input.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  // Qualification FSM; strobes default low so each lasts exactly one cycle.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state         <= LOW;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        LOW: begin
          if (s2) begin
            state <= RISE_CHK;
            cnt   <= CNT_W'(1);
          end else begin
            cnt   <= '0;
          end
        end
        RISE_CHK: begin
          if (!s2) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt == LAST_CNT) begin
            state       <= HIGH;
            cnt         <= '0;
            level       <= 1'b1;
            press_pulse <= 1'b1;
            press_count <= press_count + 8'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HIGH: begin
          if (!s2) begin
            state <= FALL_CHK;
            cnt   <= CNT_W'(1);
          end else begin
            cnt   <= '0;
          end
        end
        FALL_CHK: begin
          if (s2) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt == LAST_CNT) begin
            state         <= LOW;
            cnt           <= '0;
            level         <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_pulser.sv
// Self-checking bench for debounce_pulser: directed scenarios plus random
// bouncing input compared against a run-length reference model.
module tb_debounce_pulser;

  localparam int unsigned STABLE = 4;

  logic       clock  = 1'b0;
  logic       nreset = 1'b0;
  logic       btn_in = 1'b0;
  logic       level;
  logic       press_pulse;
  logic       release_pulse;
  logic [7:0] press_count;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: level flips once the synchronized input has differed
  // from it for STABLE consecutive samples.
  logic       m_s1, m_s2, m_level, m_press, m_release;
  logic [7:0] m_count;
  int         m_run;

  debounce_pulser #(.STABLE_CYCLES(STABLE), .CNT_W(16)) dut (
    .clock         (clock),
    .nreset        (nreset),
    .btn_in        (btn_in),
    .level         (level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .press_count   (press_count)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0; m_release = 0;
    m_count = 8'd0; m_run = 0;
  endtask

  task automatic model_edge();
    if (!nreset) begin
      model_reset();
      return;
    end
    m_press   = 0;
    m_release = 0;
    if (m_s2 != m_level) m_run++;
    else m_run = 0;
    if (m_run == int'(STABLE)) begin
      m_level = ~m_level;
      m_run   = 0;
      if (m_level) begin
        m_press = 1;
        m_count = m_count + 8'd1;
      end else begin
        m_release = 1;
      end
    end
    m_s2 = m_s1;
    m_s1 = btn_in;
  endtask

  task automatic tick(input logic b);
    btn_in = b;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  function automatic logic [10:0] dut_vec();
    return {level, press_pulse, release_pulse, press_count};
  endfunction

  function automatic logic [10:0] model_vec();
    return {m_level, m_press, m_release, m_count};
  endfunction

  task automatic test_reset();
    btn_in = 0;
    nreset = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    vectors++;
    if ({level, press_pulse, release_pulse} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags got=%b want=000", {level, press_pulse, release_pulse});
    end
    vectors++;
    if (press_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_count got=%0d want=0", press_count);
    end
    #2 nreset = 1;
    for (int i = 0; i < 4; i++) begin
      tick(0);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL reset_idle got=%b want=%b", dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_clean_press();
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      vectors++;
      if (press_pulse !== (i == 6) || level !== (i >= 6)) begin
        miscompares++;
        $display("FAIL clean_press edge=%0d got p=%b l=%b want p=%b l=%b",
                 i, press_pulse, level, (i == 6), (i >= 6));
      end
    end
    vectors++;
    if (press_count !== 8'd1) begin
      miscompares++;
      $display("FAIL clean_press_count got=%0d want=1", press_count);
    end
  endtask

  task automatic test_release();
    for (int i = 1; i <= 9; i++) begin
      tick(0);
      vectors++;
      if (release_pulse !== (i == 6) || level !== (i < 6) || press_pulse !== 1'b0) begin
        miscompares++;
        $display("FAIL release edge=%0d got r=%b l=%b p=%b want r=%b l=%b p=0",
                 i, release_pulse, level, press_pulse, (i == 6), (i < 6));
      end
    end
    vectors++;
    if (press_count !== 8'd1) begin
      miscompares++;
      $display("FAIL release_count got=%0d want=1", press_count);
    end
  endtask

  task automatic test_bounce();
    logic pattern [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      tick(pattern[i]);
      vectors++;
      if (press_pulse !== 1'b0 || level !== 1'b0) begin
        miscompares++;
        $display("FAIL bounce_phase step=%0d got p=%b l=%b want p=0 l=0", i, press_pulse, level);
      end
    end
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      vectors++;
      if (press_pulse !== (i == 6) || level !== (i >= 6)) begin
        miscompares++;
        $display("FAIL bounce_rise edge=%0d got p=%b l=%b want p=%b l=%b",
                 i, press_pulse, level, (i == 6), (i >= 6));
      end
    end
    vectors++;
    if (press_count !== 8'd2) begin
      miscompares++;
      $display("FAIL bounce_count got=%0d want=2", press_count);
    end
  endtask

  task automatic test_glitch();
    tick(0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      vectors++;
      if (release_pulse !== 1'b0 || level !== 1'b1) begin
        miscompares++;
        $display("FAIL glitch step=%0d got r=%b l=%b want r=0 l=1", i, release_pulse, level);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) tick(0);
    for (int i = 0; i < 4; i++) tick(1);
    #2 nreset = 0;
    model_reset();
    #1;
    vectors++;
    if (dut_vec() !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_mid_async got=%b want=0", dut_vec());
    end
    nreset = 1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      vectors++;
      if (press_pulse !== (i == 6) || dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL reset_mid_requal edge=%0d got=%b want=%b", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_wrap();
    int presses = 0;
    int releases = 0;
    nreset = 0;
    model_reset();
    tick(0);
    #2 nreset = 1;
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < 14; i++) begin
        tick(i < 7);
        if (press_pulse === 1'b1) presses++;
        if (release_pulse === 1'b1) releases++;
        vectors++;
        if (dut_vec() !== model_vec()) begin
          miscompares++;
          $display("FAIL wrap_model press=%0d got=%b want=%b", p, dut_vec(), model_vec());
        end
      end
      if (p == 254) begin
        vectors++;
        if (press_count !== 8'd255) begin
          miscompares++;
          $display("FAIL wrap_255 got=%0d want=255", press_count);
        end
      end
    end
    vectors++;
    if (press_count !== 8'd0 || presses != 256 || releases != 256) begin
      miscompares++;
      $display("FAIL wrap_total got count=%0d presses=%0d releases=%0d want 0/256/256",
               press_count, presses, releases);
    end
  endtask

  task automatic test_random();
    logic b = 0;
    int   run = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        b   = ~b;
        run = int'($urandom_range(1, 8));
      end
      run--;
      tick(b);
      vectors++;
      if (dut_vec() !== model_vec() || (press_pulse && release_pulse)) begin
        miscompares++;
        $display("FAIL random step=%0d got=%b want=%b", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_glitch();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
